// File: rtl/slr_xing_arbiter_if.sv
// slr_xing_arbiter_if
//  Bundles the requester streams, the registered crossing-pipe outputs and the
//  credit/status signals of one SLR-crossing arbiter.
//  Ports (all signals, grouped by direction as seen from the arbiter):
//   inputs  : req_tvalid[NUM_REQ], req_tdata[NUM_REQ*DATA_W], req_tlast[NUM_REQ],
//             credit_ret (1-cycle pulse per far-side FIFO slot freed)
//   outputs : req_tready[NUM_REQ], xing_valid, xing_data[DATA_W], xing_last,
//             xing_src[SRC_W], credit_cnt[CREDIT_W], grant_oh[NUM_REQ], credit_err
//  Modports: slave = arbiter side, master = requester / environment side.
interface slr_xing_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 256,
    parameter int CREDITS = 16
);
    localparam int SRC_W    = $clog2(NUM_REQ);
    localparam int CREDIT_W = $clog2(CREDITS + 1);

    logic [NUM_REQ-1:0]        req_tvalid;
    logic [NUM_REQ*DATA_W-1:0] req_tdata;
    logic [NUM_REQ-1:0]        req_tlast;
    logic [NUM_REQ-1:0]        req_tready;
    logic                      xing_valid;
    logic [DATA_W-1:0]         xing_data;
    logic                      xing_last;
    logic [SRC_W-1:0]          xing_src;
    logic                      credit_ret;
    logic [CREDIT_W-1:0]       credit_cnt;
    logic [NUM_REQ-1:0]        grant_oh;
    logic                      credit_err;

    modport slave (
        input  req_tvalid, req_tdata, req_tlast, credit_ret,
        output req_tready, xing_valid, xing_data, xing_last, xing_src,
               credit_cnt, grant_oh, credit_err
    );

    modport master (
        output req_tvalid, req_tdata, req_tlast, credit_ret,
        input  req_tready, xing_valid, xing_data, xing_last, xing_src,
               credit_cnt, grant_oh, credit_err
    );
endinterface

// File: rtl/slr_xing_arbiter.sv
// slr_xing_arbiter
//  Near-side arbiter for one registered inter-SLR pipe. NUM_REQ packet streams
//  share the pipe with packet-granular round-robin arbitration. Beats are only
//  accepted while credits remain, the credit pool mirroring the free slots of
//  the far-side receive FIFO, so the pipe itself never needs backpressure.
//  Ports:
//   sys_clk   : single clock, all logic on the rising edge
//   sys_rst_n : asynchronous assert, active-low reset
//   bus       : slr_xing_arbiter_if.slave (requester streams, crossing outputs,
//               credit return, credit count, grant and credit error status)
//  The NUM_REQ/DATA_W/CREDITS parameters must match those of the bound interface.
module slr_xing_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 256,
    parameter int CREDITS = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    slr_xing_arbiter_if.slave bus
);
    localparam int SRC_W    = $clog2(NUM_REQ);
    localparam int CREDIT_W = $clog2(CREDITS + 1);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(CREDITS);
    localparam logic [SRC_W:0]      NUM_REQ_W  = (SRC_W + 1)'(NUM_REQ);
    localparam logic [SRC_W-1:0]    LAST_INIT  = SRC_W'(NUM_REQ - 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t              state_reg, state_next;
    logic [NUM_REQ-1:0]  grant_reg, grant_next;
    logic [SRC_W-1:0]    last_reg, last_next;
    logic [CREDIT_W-1:0] credit_reg, credit_next;
    logic                credit_err_reg, credit_err_next;

    logic                xing_valid_reg;
    logic [DATA_W-1:0]   xing_data_reg;
    logic                xing_last_reg;
    logic [SRC_W-1:0]    xing_src_reg;

    logic                credit_avail;
    logic [NUM_REQ-1:0]  tready;
    logic                accept;
    logic [DATA_W-1:0]   lane_data [NUM_REQ];
    logic [DATA_W-1:0]   sel_data;
    logic                sel_last;

    // ------------------------------------------------------------------
    // Handshake. tready depends only on registered grant and credits, so
    // there is no combinational path from any tvalid to any tready.
    // ------------------------------------------------------------------
    assign credit_avail = (credit_reg != '0);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign tready[gi]    = grant_reg[gi] & credit_avail;
            assign lane_data[gi] = bus.req_tdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign bus.req_tready = tready;
    // grant is one-hot, so at most one lane can handshake
    assign accept   = |(bus.req_tvalid & tready);
    // last_reg always names the granted requester while in XFER
    assign sel_data = lane_data[last_reg];
    assign sel_last = bus.req_tlast[last_reg];

    // ------------------------------------------------------------------
    // Round-robin search. The request vector is rotated so bit 0 is the
    // requester just after the previous winner; the lowest set bit of the
    // rotated vector is the winner, mapped back with a modulo add.
    // ------------------------------------------------------------------
    logic [SRC_W-1:0]     rot_base;
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [SRC_W-1:0]     win_idx;
    logic                 win_found;
    logic [SRC_W:0]       win_sum;

    assign rot_base = (last_reg == LAST_INIT) ? '0 : last_reg + SRC_W'(1);
    assign req_dbl  = {bus.req_tvalid, bus.req_tvalid};
    assign req_rot  = NUM_REQ'(req_dbl >> rot_base);

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_sum   = '0;
        // descending scan: the lowest set offset is the one left standing
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_found = 1'b1;
                win_sum   = {1'b0, rot_base} + (SRC_W + 1)'(k);
                if (win_sum >= NUM_REQ_W) begin
                    win_sum = win_sum - NUM_REQ_W;
                end
                win_idx = win_sum[SRC_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Packet FSM: next-state and grant
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (win_found && credit_avail) begin
                    state_next = XFER;
                    grant_next = NUM_REQ'(1) << win_idx;
                    last_next  = win_idx;
                end
            end
            XFER: begin
                // grant survives tvalid gaps and credit stalls; only the
                // accepted tail beat releases it
                if (accept && sel_last) begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Credit accounting: accept consumes, credit_ret refunds; both in the
    // same cycle cancel. A refund with the pool already full is a far-side
    // protocol error: the count saturates and the error is latched.
    // ------------------------------------------------------------------
    always_comb begin
        credit_next     = credit_reg;
        credit_err_next = credit_err_reg;
        if (accept && !bus.credit_ret) begin
            credit_next = credit_reg - CREDIT_W'(1);
        end else if (!accept && bus.credit_ret) begin
            if (credit_reg == CREDIT_MAX) begin
                credit_err_next = 1'b1;
            end else begin
                credit_next = credit_reg + CREDIT_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_reg       <= LAST_INIT;
            credit_reg     <= CREDIT_MAX;
            credit_err_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_reg       <= last_next;
            credit_reg     <= credit_next;
            credit_err_reg <= credit_err_next;
        end
    end

    // ------------------------------------------------------------------
    // Crossing pipe register: one-cycle valid pulse per accepted beat;
    // data/last/src hold their previous value between beats.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            xing_valid_reg <= 1'b0;
            xing_data_reg  <= '0;
            xing_last_reg  <= 1'b0;
            xing_src_reg   <= '0;
        end else begin
            xing_valid_reg <= accept;
            if (accept) begin
                xing_data_reg <= sel_data;
                xing_last_reg <= sel_last;
                xing_src_reg  <= last_reg;
            end
        end
    end

    assign bus.xing_valid = xing_valid_reg;
    assign bus.xing_data  = xing_data_reg;
    assign bus.xing_last  = xing_last_reg;
    assign bus.xing_src   = xing_src_reg;
    assign bus.credit_cnt = credit_reg;
    assign bus.grant_oh   = grant_reg;
    assign bus.credit_err = credit_err_reg;

endmodule

// File: tb/tb_slr_xing_arbiter.sv
// tb_slr_xing_arbiter
//  Randomised bench for slr_xing_arbiter. A behavioural model (packet queues
//  per requester, an integer credit pool and a "who goes next" round-robin
//  search) predicts every accepted beat and pushes it into a scoreboard; an
//  independent monitor pops and compares whenever the pipe presents a beat.
//  Handshake/grant/credit outputs are compared against the model every cycle.
module tb_slr_xing_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int DATA_W   = 32;
    localparam int CREDITS  = 16;
    localparam int SRC_W    = $clog2(NUM_REQ);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [SRC_W-1:0]  src;
    } exp_t;

    logic sys_clk = 1'b0;
    logic sys_rst_n;

    slr_xing_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CREDITS(CREDITS)) bus ();

    slr_xing_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CREDITS(CREDITS)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    // stimulus and scoreboard state
    beat_t pend_q [NUM_REQ][$];
    exp_t  sb_q[$];
    int    obs_src[$];
    int    obs_cyc[$];
    int    cyc = 0;

    // reference model
    bit m_busy;
    int m_gnt;
    int m_last;
    int m_cred;
    bit m_err;
    int m_acc_cnt = 0;

    // driver knobs
    int bubble_pct = 0;
    int ret_mode   = 0;   // 0 none, 1 random when not full, 2 on every accept
    int ret_pct    = 0;
    int force_ret  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string msg);
        n_checks++;
        n_errors++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_gnt  = 0;
        m_last = NUM_REQ - 1;
        m_cred = CREDITS;
        m_err  = 1'b0;
    endtask

    // One clock edge of the reference model, using pre-edge model state.
    task automatic model_edge();
        bit    acc;
        bit    ret;
        beat_t b;
        exp_t  e;
        acc = 1'b0;
        ret = bus.credit_ret;
        if (m_busy) begin
            if (m_cred > 0 && bus.req_tvalid[m_gnt]) begin
                acc = 1'b1;
                b = pend_q[m_gnt].pop_front();
                e.data = b.data;
                e.last = b.last;
                e.src  = SRC_W'(m_gnt);
                sb_q.push_back(e);
                m_acc_cnt++;
                if (b.last) m_busy = 1'b0;
            end
        end else if (m_cred > 0) begin
            // next requester after the previous winner, wrapping around
            for (int k = 1; k <= NUM_REQ; k++) begin
                int j;
                j = (m_last + k) % NUM_REQ;
                if (bus.req_tvalid[j]) begin
                    m_busy = 1'b1;
                    m_gnt  = j;
                    m_last = j;
                    break;
                end
            end
        end
        if (ret && !acc) begin
            if (m_cred == CREDITS) m_err = 1'b1;
            else m_cred++;
        end else if (acc && !ret) begin
            m_cred--;
        end
    endtask

    always @(posedge sys_clk) begin
        cyc++;
        if (sys_rst_n) model_edge();
    end

    // Scoreboard monitor: every presented beat must match the oldest
    // predicted beat, and every predicted beat must show up exactly one
    // cycle after its accept.
    task automatic monitor_cycle();
        exp_t e;
        if (bus.xing_valid) begin
            obs_src.push_back(int'(bus.xing_src));
            obs_cyc.push_back(cyc);
            if (sb_q.size() == 0) begin
                fail("xing_unexpected", $sformatf("beat src %0d with nothing predicted", bus.xing_src));
            end else begin
                e = sb_q.pop_front();
                check("xing_data", 64'(bus.xing_data), 64'(e.data));
                check("xing_last", 64'(bus.xing_last), 64'(e.last));
                check("xing_src",  64'(bus.xing_src),  64'(e.src));
            end
        end else if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            fail("xing_missing", $sformatf("no beat, expected src %0d data 0x%0h", e.src, e.data));
        end
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst_n) monitor_cycle();
    end

    task automatic check_state();
        logic [NUM_REQ-1:0] exp_gnt;
        logic [NUM_REQ-1:0] exp_rdy;
        exp_gnt = m_busy ? (NUM_REQ'(1) << m_gnt) : '0;
        exp_rdy = (m_busy && m_cred > 0) ? exp_gnt : '0;
        check("req_tready", 64'(bus.req_tready), 64'(exp_rdy));
        check("grant_oh",   64'(bus.grant_oh),   64'(exp_gnt));
        check("credit_cnt", 64'(bus.credit_cnt), 64'(m_cred));
        check("credit_err", 64'(bus.credit_err), 64'(m_err));
    endtask

    task automatic drive();
        logic [NUM_REQ-1:0]        v;
        logic [NUM_REQ-1:0]        l;
        logic [NUM_REQ*DATA_W-1:0] d;
        logic                      r;
        v = '0;
        l = '0;
        d = '0;
        r = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            d[i*DATA_W +: DATA_W] = $urandom;
            if (pend_q[i].size() > 0 && $urandom_range(99) >= bubble_pct) begin
                v[i] = 1'b1;
                d[i*DATA_W +: DATA_W] = pend_q[i][0].data;
                l[i] = pend_q[i][0].last;
            end
        end
        if (force_ret > 0) begin
            r = 1'b1;
            force_ret--;
        end else if (ret_mode == 1) begin
            r = (m_cred < CREDITS) && ($urandom_range(99) < ret_pct);
        end else if (ret_mode == 2) begin
            r = m_busy && (m_cred > 0) && v[m_gnt];
        end
        bus.req_tvalid = v;
        bus.req_tdata  = d;
        bus.req_tlast  = l;
        bus.credit_ret = r;
    endtask

    task automatic step();
        @(negedge sys_clk);
        check_state();
        drive();
    endtask

    task automatic add_packet(input int req, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = $urandom;
            b.last = (k == len - 1);
            pend_q[req].push_back(b);
        end
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < NUM_REQ; i++)
            if (pend_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((any_pending() || m_busy || sb_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) fail({"timeout_", name}, "traffic did not drain");
    endtask

    task automatic restore_credits();
        int n;
        n = 0;
        ret_mode = 1;
        ret_pct  = 100;
        while (m_cred < CREDITS && n < 64) begin
            step();
            n++;
        end
        step();
        if (m_cred < CREDITS) fail("timeout_restore", "credits not refilled");
        ret_mode = 0;
    endtask

    // Called half a cycle clear of any clock edge.
    task automatic do_reset();
        sys_rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < NUM_REQ; i++) pend_q[i].delete();
        sb_q.delete();
        bus.req_tvalid = '0;
        bus.req_tdata  = '0;
        bus.req_tlast  = '0;
        bus.credit_ret = 1'b0;
        force_ret = 0;
        #1;
        check("rst_xing_valid", 64'(bus.xing_valid), 64'd0);
        check("rst_grant_oh",   64'(bus.grant_oh),   64'd0);
        check("rst_tready",     64'(bus.req_tready), 64'd0);
        check("rst_credit_cnt", 64'(bus.credit_cnt), 64'(CREDITS));
        check("rst_credit_err", 64'(bus.credit_err), 64'd0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        sys_rst_n      = 1'b1;
        bus.req_tvalid = '0;
        bus.req_tdata  = '0;
        bus.req_tlast  = '0;
        bus.credit_ret = 1'b0;
        model_reset();
        #1;
        do_reset();
        check("rst_xing_data", 64'(bus.xing_data), 64'd0);
        check("rst_xing_src",  64'(bus.xing_src),  64'd0);

        // single 3-beat packet from requester 0
        bubble_pct = 0;
        ret_mode   = 0;
        obs_src.delete();
        add_packet(0, 3);
        drain("single", 50);
        check("single_beats", 64'(obs_src.size()), 64'd3);
        check("single_credit", 64'(bus.credit_cnt), 64'(CREDITS - 3));
        $display("txn single: 3 beats from req0, credit_cnt=%0d", bus.credit_cnt);

        // all requesters, 1-beat packets; previous winner was 0 so order starts at 1
        obs_src.delete();
        obs_cyc.delete();
        ret_mode = 1;
        ret_pct  = 100;
        for (int rep = 0; rep < 2; rep++)
            for (int r = 0; r < NUM_REQ; r++) add_packet(r, 1);
        drain("rr", 100);
        check("rr_count", 64'(obs_src.size()), 64'(2 * NUM_REQ));
        for (int k = 0; k < obs_src.size(); k++)
            check("rr_order", 64'(obs_src[k]), 64'((1 + k) % NUM_REQ));
        for (int k = 1; k < obs_cyc.size(); k++)
            check("rr_gap", 64'(obs_cyc[k] - obs_cyc[k-1]), 64'd2);
        $display("txn rr: %0d single-beat packets, round-robin order checked", obs_src.size());

        // credit exhaustion mid-packet with grant held
        restore_credits();
        add_packet(1, CREDITS + 2);
        n = 0;
        while (!(m_cred == 0 && pend_q[1].size() == 2) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) fail("timeout_exhaust", "credits never ran out");
        for (int k = 0; k < 4; k++) begin
            step();
            check("stall_tready", 64'(bus.req_tready), 64'd0);
            check("stall_grant",  64'(bus.grant_oh),   64'b0010);
        end
        force_ret = 2;
        drain("exhaust", 50);
        check("exhaust_credit", 64'(bus.credit_cnt), 64'd0);
        check("exhaust_grant",  64'(bus.grant_oh),   64'd0);
        $display("txn exhaust: req1 %0d beats, stalled at 0 credits, credit_cnt=%0d",
                 CREDITS + 2, bus.credit_cnt);

        // credit_ret coincident with every accept at credit_cnt=2
        force_ret = 2;
        step();
        step();
        step();
        check("coinc_start", 64'(bus.credit_cnt), 64'd2);
        ret_mode = 2;
        add_packet(2, 3);
        drain("coinc", 50);
        ret_mode = 0;
        check("coinc_credit", 64'(bus.credit_cnt), 64'd2);
        $display("txn coincident: req2 3 beats with refunds, credit_cnt=%0d", bus.credit_cnt);

        // randomised traffic
        bubble_pct = 25;
        ret_mode   = 1;
        ret_pct    = 40;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(99) < 12) begin
                int r;
                r = $urandom_range(NUM_REQ - 1);
                if (pend_q[r].size() < 8) add_packet(r, $urandom_range(6, 1));
            end
            step();
        end
        drain("random", 3000);
        $display("txn random: %0d beats accepted in total", m_acc_cnt);
        bubble_pct = 0;

        // refund with a full pool: saturate and latch the error
        restore_credits();
        check("sat_err_before", 64'(bus.credit_err), 64'd0);
        force_ret = 1;
        step();
        step();
        check("sat_credit", 64'(bus.credit_cnt), 64'(CREDITS));
        check("sat_err",    64'(bus.credit_err), 64'd1);
        $display("txn saturate: credit_cnt=%0d credit_err=%0d", bus.credit_cnt, bus.credit_err);

        // reset during beat 2 of a 5-beat packet
        add_packet(3, 5);
        base = m_acc_cnt;
        n = 0;
        while (m_acc_cnt < base + 2 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) fail("timeout_midrst", "packet never started");
        #2;
        do_reset();
        obs_src.delete();
        for (int r = NUM_REQ - 1; r >= 0; r--) add_packet(r, 1);
        step();
        step();
        check("rst_first_grant", 64'(bus.grant_oh), 64'b0001);
        drain("after_rst", 100);
        check("rst_order_count", 64'(obs_src.size()), 64'(NUM_REQ));
        if (obs_src.size() > 0) check("rst_first_src", 64'(obs_src[0]), 64'd0);
        $display("txn midreset: packet abandoned, restart served req0 first");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
